// File: rtl/parser_head_gen.sv
// parser_head_gen
// Slices the first HEAD_BEATS beats of each packet into tagged head slices for
// parser layer 1, and emits one tagged meta slice per packet carrying the
// ingress port, an arrival timestamp and a packet sequence number.
//
// Ports
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_data_valid   : input beat valid
//   i_data         : packet beat, byte 0 at the most significant byte
//   i_sop, i_eop   : first / last beat of packet
//   i_empty        : invalid trailing bytes on the eop beat
//   i_port         : ingress port, sampled on the sop beat
//   o_data_ready   : beat accepted when i_data_valid && o_data_ready
//   o_head         : {data, tag} head slice, one cycle after the beat
//   o_meta         : {meta, tag} meta slice, alongside the start head slice
//   o_err_cnt      : saturating framing error counter
//
// Tag layout (low TAG_WIDTH bits): [7] valid [6] shift [5] tail [4] start
// [3:0] offset of the last valid byte in the slice.

module parser_head_gen #(
  parameter int HEAD_WIDTH = 128,
  parameter int META_WIDTH = 128,
  parameter int TAG_WIDTH  = 8,
  parameter int HEAD_BEATS = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_data_valid,
  input  logic [HEAD_WIDTH-1:0]           i_data,
  input  logic                            i_sop,
  input  logic                            i_eop,
  input  logic [3:0]                      i_empty,
  input  logic [7:0]                      i_port,
  output logic                            o_data_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic [15:0]                     o_err_cnt
);

  localparam int CNT_W    = $clog2(HEAD_BEATS + 1);
  localparam int META_PAD = META_WIDTH - 56;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HEAD_BEATS);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAD    = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [31:0]                     ts;
  logic [15:0]                     seq;
  logic [15:0]                     err_cnt;
  logic                            err_inc;
  logic                            seq_inc;
  logic                            accept;
  logic                            start_pkt;
  logic                            tail;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_p0, head_p1;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_p0, meta_p1;
  logic [META_WIDTH-1:0]           meta_data;

  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic       tail_f,
                                                    input logic       start_f,
                                                    input logic [3:0] offset_f);
    logic [TAG_WIDTH-1:0] t;
    t      = '0;
    t[7]   = 1'b1;
    t[6]   = 1'b1;
    t[5]   = tail_f;
    t[4]   = start_f;
    t[3:0] = offset_f;
    return t;
  endfunction

  function automatic logic [3:0] beat_offset(input logic eop_f, input logic [3:0] empty_f);
    return eop_f ? (4'd15 - empty_f) : 4'd15;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Ready is withheld in GAP and whenever a sop collides with an open head,
  // so the colliding sop is held by the source and accepted next cycle.
  always_comb begin
    o_data_ready = 1'b1;
    if (i_rst || (state == GAP) || ((state == HEAD) && i_data_valid && i_sop)) begin
      o_data_ready = 1'b0;
    end
  end

  assign accept    = i_data_valid && o_data_ready;
  assign meta_data = {i_port, ts, seq, {META_PAD{1'b0}}};

  // A sop accepted in IDLE or PAYLOAD opens a new packet.
  assign start_pkt = accept && i_sop && ((state == IDLE) || (state == PAYLOAD));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    head_p0   = '0;
    meta_p0   = '0;
    err_inc   = 1'b0;
    seq_inc   = 1'b0;
    tail      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept && !i_sop) begin
          err_inc = 1'b1;
        end
      end
      HEAD: begin
        if (i_data_valid && i_sop) begin
          // Close the truncated packet with an empty tail so layer 1 resyncs.
          head_p0   = {{HEAD_WIDTH{1'b0}}, make_tag(1'b1, 1'b0, 4'd0)};
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end else if (accept) begin
          cnt_nxt = cnt + ONE_BEAT;
          tail    = i_eop || (cnt_nxt == LAST_BEAT);
          head_p0 = {i_data, make_tag(tail, 1'b0, beat_offset(i_eop, i_empty))};
          if (i_eop) begin
            state_nxt = GAP;
          end else if (tail) begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (i_sop) begin
            err_inc = 1'b1;
          end else if (i_eop) begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
    endcase

    if (start_pkt) begin
      cnt_nxt   = ONE_BEAT;
      tail      = i_eop || (ONE_BEAT == LAST_BEAT);
      head_p0   = {i_data, make_tag(tail, 1'b1, beat_offset(i_eop, i_empty))};
      meta_p0   = {meta_data, make_tag(1'b1, 1'b1, 4'd15)};
      seq_inc   = 1'b1;
      if (i_eop) begin
        state_nxt = GAP;
      end else if (tail) begin
        state_nxt = PAYLOAD;
      end else begin
        state_nxt = HEAD;
      end
    end
  end

  // p0 -> p1: control state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ts      <= '0;
      seq     <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ts    <= ts + 32'd1;
      if (seq_inc) begin
        seq <= seq + 16'd1;
      end
      if (err_inc) begin
        err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  // p0 -> p1: output slices, cleared on reset so no partial packet leaks out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_p1 <= '0;
      meta_p1 <= '0;
    end else begin
      head_p1 <= head_p0;
      meta_p1 <= meta_p0;
    end
  end

  assign o_head    = head_p1;
  assign o_meta    = meta_p1;
  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_parser_head_gen.sv
// tb_parser_head_gen
// Directed scenarios plus randomized traffic for parser_head_gen, checked each
// cycle against a packet-level reference model; a second instance built with
// a one-beat head window streams back-to-back sops to reach sequence-number
// wrap and error-counter saturation within a short run.

module tb_parser_head_gen;

  localparam int HB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [127:0] data;
  logic         sop;
  logic         eop;
  logic [3:0]   empty;
  logic [7:0]   port;

  logic         ready, ready2;
  logic [135:0] head, head2;
  logic [135:0] meta, meta2;
  logic [15:0]  err, err2;

  int errors = 0;
  int checks = 0;

  // Reference model: packet-level view of the stream
  bit        m_in_pkt;
  bit        m_gap;
  int        m_nb;
  bit [15:0] m_seq;
  int        m_errs;
  bit [31:0] m_ts;

  logic         exp_ready;
  logic [135:0] exp_head;
  logic [135:0] exp_meta;
  logic [15:0]  exp_err;

  parser_head_gen #(
    .HEAD_WIDTH(128), .META_WIDTH(128), .TAG_WIDTH(8), .HEAD_BEATS(HB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid), .i_data(data),
    .i_sop(sop), .i_eop(eop), .i_empty(empty), .i_port(port),
    .o_data_ready(ready), .o_head(head), .o_meta(meta), .o_err_cnt(err)
  );

  parser_head_gen #(
    .HEAD_WIDTH(128), .META_WIDTH(128), .TAG_WIDTH(8), .HEAD_BEATS(1)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid), .i_data(data),
    .i_sop(sop), .i_eop(eop), .i_empty(empty), .i_port(port),
    .o_data_ready(ready2), .o_head(head2), .o_meta(meta2), .o_err_cnt(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] tagf(input bit tl, input bit st, input logic [3:0] off);
    return {2'b11, tl, st, off};
  endfunction

  task automatic drive(input bit v, input bit s, input bit e, input logic [3:0] emp,
                       input logic [7:0] p, input logic [127:0] d);
    valid = v; sop = s; eop = e; empty = emp; port = p; data = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_step();
    bit         acc;
    logic [3:0] off;
    exp_head = '0;
    exp_meta = '0;
    if (rst) begin
      m_in_pkt = 0; m_gap = 0; m_nb = 0; m_seq = 0; m_errs = 0; m_ts = 0;
    end else begin
      acc = valid && exp_ready;
      off = eop ? 4'(15 - int'(empty)) : 4'd15;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_in_pkt && m_nb < HB && valid && sop) begin
        exp_head = {128'b0, tagf(1, 0, 4'd0)};
        m_errs++;
        m_in_pkt = 0;
      end else if (acc && sop) begin
        if (m_in_pkt) m_errs++;
        m_in_pkt = 1;
        m_nb = 1;
        exp_head = {data, tagf(eop || m_nb == HB, 1, off)};
        exp_meta = {port, m_ts, m_seq, 72'b0, tagf(1, 1, 4'd15)};
        m_seq++;
        if (eop) begin m_in_pkt = 0; m_gap = 1; end
      end else if (acc && !m_in_pkt) begin
        m_errs++;
      end else if (acc) begin
        if (m_nb < HB) begin
          m_nb++;
          exp_head = {data, tagf(eop || m_nb == HB, 0, off)};
        end
        if (eop) begin m_in_pkt = 0; m_gap = 1; end
      end
      m_ts++;
    end
    exp_err = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
  endtask

  // One clock with the currently driven inputs; checks ready before the edge
  // and the registered outputs just after it.
  task automatic cyc();
    @(negedge clk);
    exp_ready = !rst && !m_gap && !(m_in_pkt && m_nb < HB && valid && sop);
    chk("ready", 136'(ready), 136'(exp_ready));
    model_step();
    @(posedge clk);
    #1;
    chk("head", head, exp_head);
    chk("meta", meta, exp_meta);
    chk("err_cnt", 136'(err), 136'(exp_err));
  endtask

  initial begin
    logic [127:0] d1, d2;

    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 4'd0, 8'd0, 128'd0);
    cyc();
    cyc();
    chk("rst_head", head, 136'd0);
    chk("rst_err", 136'(err), 136'd0);
    rst = 1'b0;

    // Two-beat packet on port 3, eop with 6 empty bytes
    d1 = rnd128();
    d2 = rnd128();
    drive(1, 1, 0, 4'd0, 8'd3, d1);
    cyc();
    chk("p2_s1_tag", 136'(head[7:0]), 136'(8'hDF));
    chk("p2_s1_data", 136'(head[135:8]), 136'(d1));
    chk("p2_meta_port", 136'(meta[135:128]), 136'(8'd3));
    chk("p2_meta_seq", 136'(meta[95:80]), 136'(16'd0));
    chk("p2_meta_tag", 136'(meta[7:0]), 136'(8'hFF));
    drive(1, 0, 1, 4'd6, 8'd0, d2);
    cyc();
    chk("p2_s2_tag", 136'(head[7:0]), 136'(8'hE9));
    chk("p2_s2_data", 136'(head[135:8]), 136'(d2));
    drive(0, 0, 0, 4'd0, 8'd0, 128'd0);
    #1;
    chk("p2_gap_ready", 136'(ready), 136'd0);
    cyc();

    // Stray non-sop beat in IDLE
    drive(1, 0, 0, 4'd0, 8'd0, rnd128());
    cyc();
    chk("stray_head", head, 136'd0);
    chk("stray_err", 136'(err), 136'd1);

    // Six-beat packet: four head slices then two discarded payload beats
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 0, i == 5, 4'd2, 8'd7, rnd128());
      cyc();
      if (i == 3) chk("p6_tail_tag", 136'(head[7:0]), 136'(8'hEF));
      if (i >= 4) chk("p6_payload_quiet", head, 136'd0);
    end
    drive(0, 0, 0, 4'd0, 8'd0, 128'd0);
    #1;
    chk("p6_gap_ready", 136'(ready), 136'd0);
    cyc();

    // sop collides with an open head after two beats
    drive(1, 1, 0, 4'd0, 8'd9, rnd128());
    cyc();
    drive(1, 0, 0, 4'd0, 8'd9, rnd128());
    cyc();
    drive(1, 1, 0, 4'd0, 8'd10, rnd128());
    #1;
    chk("coll_ready", 136'(ready), 136'd0);
    cyc();
    chk("coll_tail_only", head, {128'b0, 8'hE0});
    chk("coll_err", 136'(err), 136'd2);
    cyc();
    chk("coll_new_seq", 136'(meta[95:80]), 136'(16'd3));
    chk("coll_new_port", 136'(meta[135:128]), 136'(8'd10));
    drive(1, 0, 1, 4'd0, 8'd0, rnd128());
    cyc();
    drive(0, 0, 0, 4'd0, 8'd0, 128'd0);
    cyc();

    // Reset in the middle of a head
    drive(1, 1, 0, 4'd0, 8'd4, rnd128());
    cyc();
    drive(1, 0, 0, 4'd0, 8'd4, rnd128());
    rst = 1'b1;
    cyc();
    chk("mid_rst_head", head, 136'd0);
    chk("mid_rst_meta", meta, 136'd0);
    chk("mid_rst_err", 136'(err), 136'd0);
    rst = 1'b0;
    drive(1, 1, 0, 4'd0, 8'd5, rnd128());
    cyc();
    chk("post_rst_seq", 136'(meta[95:80]), 136'd0);
    chk("post_rst_ts", 136'(meta[127:96]), 136'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(199) == 0);
      drive($urandom_range(9) < 7, $urandom_range(3) == 0, $urandom_range(9) < 3,
            4'($urandom_range(15)), 8'($urandom_range(255)), rnd128());
      cyc();
    end

    // Back-to-back sops into the one-beat-head instance
    rst = 1'b1;
    drive(0, 0, 0, 4'd0, 8'd0, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 1, 0, 4'd0, 8'd1, 128'd0);
    for (int k = 0; k <= 70000; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("wrap_ready", 136'(ready2), 136'd1);
        chk("wrap_tag", 136'(head2[7:0]), 136'(8'hFF));
        chk("wrap_seq1", 136'(meta2[95:80]), 136'd1);
        chk("wrap_err1", 136'(err2), 136'd1);
      end
      if (k == 65535) begin
        chk("wrap_seq_max", 136'(meta2[95:80]), 136'(16'hFFFF));
        chk("sat_err_reach", 136'(err2), 136'(16'hFFFF));
      end
      if (k == 65536) chk("wrap_seq_zero", 136'(meta2[95:80]), 136'd0);
      if (k == 70000) begin
        chk("sat_err_hold", 136'(err2), 136'(16'hFFFF));
        chk("ts_70000", 136'(meta2[127:96]), 136'd70000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parser_head_gen.md
PARSER_HEAD_GEN -- requirements
Module: parser_head_gen

Interface
REQ-001 SHALL have parameter HEAD_WIDTH, default 128, head slice data width (16 bytes).
REQ-002 SHALL have parameter META_WIDTH, default 128, meta slice data width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, tag layout [7] valid, [6] shift, [5] tail, [4] start, [3:0] offset.
REQ-004 SHALL have parameter HEAD_BEATS, default 4, maximum head slices per packet.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port i_clk  input  1  clock.
REQ-007 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port i_data_valid  input  1  input beat valid.
REQ-009 SHALL have port i_data  input  128  packet beat, byte 0 at [127:120].
REQ-010 SHALL have port i_sop / i_eop  input  1 each  first / last beat of packet.
REQ-011 SHALL have port i_empty  input  4  invalid trailing bytes on the eop beat.
REQ-012 SHALL have port i_port  input  8  ingress port, sampled on the sop beat.
REQ-013 SHALL have port o_data_ready  output  1  beat accepted when valid&&ready.
REQ-014 SHALL have port o_head  output  HEAD_WIDTH+TAG_WIDTH  head slice, tag in the low TAG_WIDTH bits; feeds parser layer 1.
REQ-015 SHALL have port o_meta  output  META_WIDTH+TAG_WIDTH  meta slice, same tag layout.
REQ-016 SHALL have port o_err_cnt  output  16  framing error counter.

Function
REQ-017 SHALL implement FSM states IDLE, HEAD, PAYLOAD, GAP; reset state IDLE.
REQ-018 SHALL drive o_data_ready = 0 in GAP, 0 during reset, 0 in HEAD when i_data_valid&&i_sop, otherwise 1 (combinational from state and inputs).
REQ-019 SHALL register o_head/o_meta: the slice for a beat accepted in cycle N appears in cycle N+1, valid for exactly one cycle; otherwise all-zero.
REQ-020 IDLE: accepted sop beat -> emit head slice with valid=1, shift=1, start=1; beat counter=1; go HEAD (or GAP if also eop).
REQ-021 IDLE: accepted beat without sop SHALL be dropped with no output, and o_err_cnt incremented.
REQ-022 HEAD: each accepted beat emits a slice with valid=1, shift=1, start=0; beat counter increments.
REQ-023 Tail=1 SHALL be set on the slice of the eop beat or of the HEAD_BEATS-th beat, whichever comes first.
REQ-024 Offset SHALL be 15 for non-eop slices and 15-i_empty for the eop slice.
REQ-025 After the tail slice: eop -> GAP; no eop -> PAYLOAD.
REQ-026 PAYLOAD: accepted beats SHALL be discarded; eop -> GAP.
REQ-027 PAYLOAD: sop beat SHALL count an error and be treated as a new packet per REQ-020.
REQ-028 GAP SHALL last exactly one cycle, then go to IDLE.
REQ-029 HEAD: a valid sop beat (not accepted) SHALL emit a tail-only slice next cycle (valid=1, shift=1, tail=1, start=0, offset=0, data=0), increment o_err_cnt, and go to IDLE; the sop beat is accepted in the following cycle.
REQ-030 Meta slice SHALL be emitted in the same cycle as the head start slice, with tag valid=1, shift=1, start=1, tail=1, offset=15.
REQ-031 Meta data SHALL be [127:120] i_port, [119:88] timestamp, [87:72] sequence number, remaining bits 0.
REQ-032 Timestamp SHALL be a free-running 32-bit counter, +1 every cycle, wrapping at 2^32, sampled at sop acceptance.
REQ-033 Sequence number SHALL be 16 bits, incremented after each sop acceptance, wrapping 0xFFFF->0.
REQ-034 o_err_cnt SHALL saturate at 0xFFFF.

Reset
REQ-035 While i_rst=1 at a clock edge: state IDLE; o_head, o_meta, o_err_cnt, timestamp, sequence number and beat counter all 0; an in-flight packet SHALL be abandoned with no tail emitted.

Verification
REQ-036 2-beat packet (sop, then eop with i_empty=6), port 3 -> slice 1: start, offset 15; slice 2: tail, offset 9; meta port 3, seq 0; o_data_ready=0 for one cycle after eop.
REQ-037 6-beat packet -> 4 head slices, tail on slice 4; beats 5-6 produce no output; GAP after eop.
REQ-038 Non-sop beat in IDLE -> no output, o_err_cnt=1.
REQ-039 sop arrives in HEAD after 2 beats -> tail-only slice, ready=0 that cycle, new packet starts next cycle with seq+1, o_err_cnt+1.
REQ-040 Reset asserted mid-HEAD -> all outputs 0 next cycle; the next sop gets seq 0 and timestamp restarted from 0.
REQ-041 65537 packets -> seq wraps to 0; o_err_cnt held at 0xFFFF after 70000 errors.
